// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for the bit-serial subtractor.
// The master issues operands; the slave returns the difference and the final borrow.
`timescale 1ns/1ps
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b (mod 2^WIDTH) with final borrow.
// Works LSB first, one bit per clock, through a full-subtractor cell and a borrow flop.
`timescale 1ns/1ps
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             bit_d;
    logic             br_next;
    logic [WIDTH-1:0] sr_shift;

    always_comb begin
        bit_d    = sa_q[0] ^ sb_q[0] ^ br_q;
        br_next  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
        sr_shift = {bit_d, sr_q[WIDTH-1:1]};

        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        case (state_q)
            // DONE accepts a new request just like IDLE so back-to-back ops lose no cycle
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                br_d  = br_next;
                sr_d  = sr_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    diff_d  = sr_shift;
                    bout_d  = br_next;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=16.
// Drivers push expected results as operations are accepted; monitors pop and compare on done.
`timescale 1ns/1ps
module tb_serial_subtractor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst8, rst16;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor_if #(.WIDTH(8))  if8 ();
    serial_subtractor_if #(.WIDTH(16)) if16 ();

    serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst8),  .bus(if8));
    serial_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst16), .bus(if16));

    typedef struct {
        logic [15:0] diff;
        logic        bout;
        int          done_cyc;
    } exp_t;

    exp_t        q8[$];
    exp_t        q16[$];
    logic [15:0] last_d8, last_d16;
    logic        last_b8, last_b16;
    bit          mon8 = 1'b0;
    bit          mon16 = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain integer subtraction reduced modulo 2^w; borrow is unsigned a < b.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input int dc);
        exp_t e;
        int   d;
        int   mask;
        mask       = (1 << w) - 1;
        d          = int'(a) - int'(b);
        e.diff     = 16'(d & mask);
        e.bout     = (a < b);
        e.done_cyc = dc;
        return e;
    endfunction

    task automatic mon_step(input string tag, ref exp_t q[$], ref logic [15:0] last_d,
                            ref logic last_b, input logic done, input logic busy,
                            input logic [15:0] diff, input logic bout);
        exp_t e;
        logic exp_done, exp_busy;
        exp_done = (q.size() > 0) && (cyc == q[0].done_cyc);
        exp_busy = (q.size() > 0) && (cyc < q[0].done_cyc);
        chk({tag, "_done"}, 16'(done), 16'(exp_done));
        chk({tag, "_busy"}, 16'(busy), 16'(exp_busy));
        if ((q.size() > 0) && (cyc >= q[0].done_cyc)) begin
            e = q.pop_front();
            if (done) begin
                chk({tag, "_diff"}, diff, e.diff);
                chk({tag, "_bout"}, 16'(bout), 16'(e.bout));
            end
            last_d = e.diff;
            last_b = e.bout;
        end else begin
            chk({tag, "_diff_hold"}, diff, last_d);
            chk({tag, "_bout_hold"}, 16'(bout), 16'(last_b));
        end
    endtask

    always @(negedge clk) begin
        if (mon8)
            mon_step("w8", q8, last_d8, last_b8, if8.done, if8.busy, 16'(if8.diff), if8.bout);
        if (mon16)
            mon_step("w16", q16, last_d16, last_b16, if16.done, if16.busy, if16.diff, if16.bout);
    end

    // One operation; start is pulsed for the accept edge, then operands and start are
    // scrambled while RUN to show they are ignored. Returns in the DONE cycle plus gap.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input int gap);
        if8.a = a; if8.b = b; if8.start = 1'b1;
        @(posedge clk); #1;
        q8.push_back(model(8, 16'(a), 16'(b), cyc + 8));
        for (int i = 0; i < 8; i++) begin
            if8.start = ($urandom_range(0, 3) == 0);
            if8.a = 8'($urandom);
            if8.b = 8'($urandom);
            @(posedge clk); #1;
        end
        if8.start = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input int gap);
        if16.a = a; if16.b = b; if16.start = 1'b1;
        @(posedge clk); #1;
        q16.push_back(model(16, a, b, cyc + 16));
        for (int i = 0; i < 16; i++) begin
            if16.start = ($urandom_range(0, 3) == 0);
            if16.a = 16'($urandom);
            if16.b = 16'($urandom);
            @(posedge clk); #1;
        end
        if16.start = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic drv8();
        rst8 = 1'b1; if8.start = 1'b0; if8.a = '0; if8.b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst8 = 1'b0;
        last_d8 = '0; last_b8 = 1'b0;
        chk("rst8_busy", 16'(if8.busy), 16'h0);
        chk("rst8_done", 16'(if8.done), 16'h0);
        chk("rst8_diff", 16'(if8.diff), 16'h0);
        chk("rst8_bout", 16'(if8.bout), 16'h0);
        mon8 = 1'b1;

        op8(8'd100, 8'd37, 1);
        op8(8'd5, 8'd9, 0);
        op8(8'd0, 8'd1, 0);
        op8(8'd255, 8'd255, 2);

        // start held through the whole op; second op accepted in the DONE cycle
        if8.a = 8'd200; if8.b = 8'd13; if8.start = 1'b1;
        @(posedge clk); #1;
        q8.push_back(model(8, 16'd200, 16'd13, cyc + 8));
        for (int i = 0; i < 7; i++) begin
            if8.a = 8'($urandom); if8.b = 8'($urandom);
            @(posedge clk); #1;
        end
        if8.a = 8'd50; if8.b = 8'd77;
        @(posedge clk); #1;
        @(posedge clk); #1;
        q8.push_back(model(8, 16'd50, 16'd77, cyc + 8));
        if8.start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end

        // reset three cycles into RUN discards the operation
        if8.a = 8'd3; if8.b = 8'd4; if8.start = 1'b1;
        @(posedge clk); #1;
        q8.push_back(model(8, 16'd3, 16'd4, cyc + 8));
        if8.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst8 = 1'b1;
        @(posedge clk); #1;
        rst8 = 1'b0;
        q8.delete();
        last_d8 = '0; last_b8 = 1'b0;
        chk("abort8_busy", 16'(if8.busy), 16'h0);
        chk("abort8_done", 16'(if8.done), 16'h0);
        chk("abort8_diff", 16'(if8.diff), 16'h0);
        chk("abort8_bout", 16'(if8.bout), 16'h0);
        repeat (15) begin @(posedge clk); #1; end

        for (int n = 0; n < 1000; n++)
            op8(8'($urandom), 8'($urandom), $urandom_range(0, 2));
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic drv16();
        rst16 = 1'b1; if16.start = 1'b0; if16.a = '0; if16.b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst16 = 1'b0;
        last_d16 = '0; last_b16 = 1'b0;
        chk("rst16_busy", 16'(if16.busy), 16'h0);
        chk("rst16_diff", if16.diff, 16'h0);
        mon16 = 1'b1;

        op16(16'h0000, 16'h0001, 0);
        op16(16'hFFFF, 16'hFFFF, 1);
        op16(16'h8000, 16'h7FFF, 0);
        for (int n = 0; n < 1000; n++)
            op16(16'($urandom), 16'($urandom), $urandom_range(0, 2));
        repeat (3) begin @(posedge clk); #1; end
    endtask

    initial begin
        fork
            drv8();
            drv16();
        join
        chk("q8_drained", 16'(q8.size()), 16'h0);
        chk("q16_drained", 16'(q16.size()), 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "time limit");
    end
endmodule
